bitstream_decoder: RTL and testbench
====================================

// Module: bitstream_decoder
// PURPOSE
//   Converts stochastic bitstreams back to binary counts at the output side of the bitstream network.
//   - Counts ones on each channel over a window of up to LENGTH cycles, framed by `compute`.
//   - Each window opens on a compute rising edge and closes when LENGTH bits are counted or compute drops.
//   - Latches the final counts into a valid/ready output register. The accumulators and the output
//     register are separate, so the next window can count while the previous result waits.
// PARAMETERS
//   CHANNELS  1                     number of independent bitstream lanes
//   LENGTH    256                   bits per full window (>=2)
//   CW        $clog2(LENGTH+1)      count width; 9 at default, so 256 is representable
// PORTS
//   clk        in   1             clock, all logic on rising edge
//   rst        in   1             synchronous reset, active-high
//   compute    in   1             window enable; high while the bitstream is valid
//   bit_in     in   CHANNELS      one stochastic bit per channel per cycle
//   count_out  out  CHANNELS*CW   latched ones-count; channel c at [c*CW +: CW]
//   out_valid  out  1             count_out holds an unconsumed result
//   out_ready  in   1             consumer accepts the result when out_valid && out_ready
//   short_win  out  1             latched result came from a window with fewer than LENGTH bits
//   busy       out  1             high in COUNT and LATCH
//   overrun    out  1             sticky: a completed result was dropped; cleared only by rst
// BEHAVIOUR
//   Reset
//     - rst=1 at an edge: state=IDLE; accumulators, cycle counter, count_out, out_valid, short_win,
//       overrun all 0. Reset applies in any state; any partial window is discarded.
//   Sampling rule
//     - bit_in is sampled at an edge only when compute=1 and state is IDLE or COUNT.
//     - An all-ones full window yields LENGTH.
//   IDLE
//     - compute=1: acc[c]=bit_in[c], ncyc=1, go to COUNT.
//   COUNT
//     - compute=1: acc[c]+=bit_in[c], ncyc++. If this was the LENGTH-th bit, go to LATCH with short=0.
//     - compute=0: nothing sampled; go to LATCH with short=1.
//   LATCH (one cycle, no sampling)
//     - If !out_valid or out_ready: count_out<=acc, short_win<=short, out_valid<=1.
//     - Otherwise overrun<=1; the new result is dropped and the old count_out is kept.
//     - Next state: DRAIN if compute=1, else IDLE.
//   DRAIN
//     - Bits are ignored until compute=0, then go to IDLE. This stops a held-high compute from
//       starting a misaligned window.
//   Output handshake
//     - Outside LATCH, out_valid && out_ready clears out_valid at that edge.
//     - count_out and short_win stay stable while out_valid=1 and no transfer occurs.
//     - LATCH with out_ready=1 and out_valid=1 transfers the old result and loads the new one in the
//       same edge; out_valid stays 1.
//   Latency and timing
//     - out_valid rises at the edge after the edge that sampled the final bit (full window), or after
//       the first compute=0 edge (short window).
//     - A full window followed by one compute-low cycle gives a next-window restart with no loss.
//   Arithmetic
//     - Accumulators are CW bits and cannot overflow, since ncyc <= LENGTH.
// TESTING
//   1. rst, then compute=1 for 256 cycles with bit_in=1, then compute=0
//      -> count_out=256, short_win=0, out_valid one edge after the 256th bit.
//   2. bit_in alternating 1,0 for 256 cycles -> count_out=128. bit_in=0 for 256 cycles -> count_out=0.
//   3. compute=1 for 100 cycles, all ones, then compute=0 -> count_out=100, short_win=1.
//   4. Hold out_ready=0 through two back-to-back windows (counts 40 then 200)
//      -> count_out stays 40, overrun=1; then out_ready=1 -> transfer 40, out_valid=0.
//   5. Assert rst at cycle 130 of a window, then run a clean all-ones window
//      -> no out_valid from the aborted window; next result=256, overrun=0.
//   6. CHANNELS=2, LFSR comparator streams encoding 107 and 89 (seed 8'b10001101)
//      -> each count equals the golden model count exactly.

Source files
------------

// File: rtl/bitstream_decoder_if.sv
// Handshake/data bundle for bitstream_decoder.
//   compute    window enable, high while the bitstreams are valid
//   bit_in     one stochastic bit per channel per cycle
//   count_out  latched ones-count, channel c at [c*CW +: CW]
//   out_valid  count_out holds an unconsumed result
//   out_ready  consumer accepts the result when out_valid && out_ready
//   short_win  latched result came from a window shorter than LENGTH
//   busy       decoder is counting or latching
//   overrun    sticky: a completed result was dropped
// master = producer/consumer side (testbench), slave = decoder side.
interface bitstream_decoder_if #(
  parameter int CHANNELS = 1,
  parameter int CW       = 9
);
  logic                   compute;
  logic [CHANNELS-1:0]    bit_in;
  logic [CHANNELS*CW-1:0] count_out;
  logic                   out_valid;
  logic                   out_ready;
  logic                   short_win;
  logic                   busy;
  logic                   overrun;

  modport master (
    output compute, bit_in, out_ready,
    input  count_out, out_valid, short_win, busy, overrun
  );

  modport slave (
    input  compute, bit_in, out_ready,
    output count_out, out_valid, short_win, busy, overrun
  );
endinterface

// File: rtl/bitstream_decoder.sv
// bitstream_decoder: counts ones on each stochastic bitstream lane over a
// window framed by compute (at most LENGTH bits), then latches the counts
// into a valid/ready output register. Accumulators and the output register
// are separate, so a new window can count while the previous result waits.
// Ports:
//   clk   clock, all logic on the rising edge
//   rst   synchronous reset, active-high
//   bus   bitstream_decoder_if.slave (compute, bit_in, count_out,
//         out_valid, out_ready, short_win, busy, overrun)
module bitstream_decoder #(
  parameter int CHANNELS = 1,
  parameter int LENGTH   = 256,
  parameter int CW       = $clog2(LENGTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  bitstream_decoder_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_LATCH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          acc_q [CHANNELS];
  logic [CW-1:0]          acc_d [CHANNELS];
  logic [CW-1:0]          ncyc_q, ncyc_d;
  logic                   pend_short_q, pend_short_d;
  logic [CHANNELS*CW-1:0] count_q, count_d;
  logic                   valid_q, valid_d;
  logic                   short_q, short_d;
  logic                   ovr_q, ovr_d;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    ncyc_d       = ncyc_q;
    pend_short_d = pend_short_q;
    count_d      = count_q;
    valid_d      = valid_q;
    short_d      = short_q;
    ovr_d        = ovr_q;

    // LATCH owns the output register that cycle (it may transfer and reload
    // in one edge), so the plain consume only applies elsewhere.
    if (state_q != ST_LATCH && valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.compute) begin
          for (int c = 0; c < CHANNELS; c++) begin
            acc_d[c] = CW'(bus.bit_in[c]);
          end
          ncyc_d  = CW'(1);
          state_d = ST_COUNT;
        end
      end

      ST_COUNT: begin
        if (bus.compute) begin
          for (int c = 0; c < CHANNELS; c++) begin
            acc_d[c] = acc_q[c] + CW'(bus.bit_in[c]);
          end
          ncyc_d = ncyc_q + CW'(1);
          // ncyc_q bits already taken; this edge takes bit number ncyc_q+1.
          if (ncyc_q == CW'(LENGTH - 1)) begin
            pend_short_d = 1'b0;
            state_d      = ST_LATCH;
          end
        end else begin
          pend_short_d = 1'b1;
          state_d      = ST_LATCH;
        end
      end

      ST_LATCH: begin
        if (!valid_q || bus.out_ready) begin
          for (int c = 0; c < CHANNELS; c++) begin
            count_d[c*CW +: CW] = acc_q[c];
          end
          short_d = pend_short_q;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
        // A compute still held high must not open a misaligned window.
        state_d = bus.compute ? ST_DRAIN : ST_IDLE;
      end

      ST_DRAIN: begin
        if (!bus.compute) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= '0;
      end
      ncyc_q       <= '0;
      pend_short_q <= 1'b0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      short_q      <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ncyc_q       <= ncyc_d;
      pend_short_q <= pend_short_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      short_q      <= short_d;
      ovr_q        <= ovr_d;
    end
  end

  assign bus.count_out = count_q;
  assign bus.out_valid = valid_q;
  assign bus.short_win = short_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = (state_q == ST_COUNT) || (state_q == ST_LATCH);

endmodule

// File: tb/tb_bitstream_decoder.sv
// Testbench for bitstream_decoder (CHANNELS=2, LENGTH=256): directed
// windows plus randomized traffic, all compared against a window-level
// reference model kept in the bench.
module tb_bitstream_decoder;
  localparam int CH  = 2;
  localparam int LEN = 256;
  localparam int CW  = $clog2(LEN + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bitstream_decoder_if #(.CHANNELS(CH), .CW(CW)) bus ();

  bitstream_decoder #(.CHANNELS(CH), .LENGTH(LEN), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model, described in terms of windows and results rather
  // than states: a window is open and collecting bits, a finished window
  // is waiting one cycle to be presented, or we wait for compute to fall.
  bit m_open, m_pending, m_wait_low, m_pend_short;
  int m_len;
  int m_sum [CH];
  bit m_valid, m_short, m_ovr;
  int m_cnt [CH];

  function automatic void model_reset();
    m_open = 0; m_pending = 0; m_wait_low = 0; m_pend_short = 0; m_len = 0;
    m_valid = 0; m_short = 0; m_ovr = 0;
    for (int c = 0; c < CH; c++) begin m_sum[c] = 0; m_cnt[c] = 0; end
  endfunction

  function automatic void model_edge(input bit c_in, input bit [CH-1:0] b, input bit rdy);
    if (m_pending) begin
      // Finished window is offered to the output register.
      if (!m_valid || rdy) begin
        for (int c = 0; c < CH; c++) m_cnt[c] = m_sum[c];
        m_short = m_pend_short;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
      m_pending  = 0;
      m_wait_low = c_in;
    end else begin
      if (m_valid && rdy) m_valid = 0;
      if (m_wait_low) begin
        if (!c_in) m_wait_low = 0;
      end else if (m_open) begin
        if (c_in) begin
          for (int c = 0; c < CH; c++) m_sum[c] += int'(b[c]);
          m_len++;
          if (m_len == LEN) begin
            m_open = 0; m_pending = 1; m_pend_short = 0;
          end
        end else begin
          m_open = 0; m_pending = 1; m_pend_short = 1;
        end
      end else if (c_in) begin
        m_open = 1; m_len = 1;
        for (int c = 0; c < CH; c++) m_sum[c] = int'(b[c]);
      end
    end
  endfunction

  // One clock: drive inputs, advance model at the edge, check after it.
  task automatic cyc(input bit c_in, input bit [CH-1:0] b, input bit rdy, input bit r);
    rst           = r;
    bus.compute   = c_in;
    bus.bit_in    = b;
    bus.out_ready = rdy;
    @(posedge clk);
    if (r) model_reset();
    else   model_edge(c_in, b, rdy);
    #1;
    chk("out_valid", int'(bus.out_valid), int'(m_valid));
    chk("short_win", int'(bus.short_win), int'(m_short));
    chk("overrun",   int'(bus.overrun),   int'(m_ovr));
    chk("busy",      int'(bus.busy),      int'(m_open || m_pending));
    for (int c = 0; c < CH; c++)
      chk("count_out", int'(bus.count_out[c*CW +: CW]), m_cnt[c]);
  endtask

  bit [7:0] lfsr;
  function automatic bit [7:0] lfsr_next(input bit [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  initial begin
    int g0, g1;
    model_reset();
    rst = 1'b1; bus.compute = 0; bus.bit_in = '0; bus.out_ready = 0;
    cyc(0, 2'b00, 0, 1);
    cyc(0, 2'b00, 0, 1);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_count", int'(bus.count_out), 0);
    cyc(0, 2'b00, 0, 0);

    // 1: full all-ones window, result one edge after the 256th bit.
    for (int i = 0; i < LEN; i++) cyc(1, 2'b11, 0, 0);
    chk("t1_notyet", int'(bus.out_valid), 0);
    cyc(0, 2'b00, 0, 0);
    chk("t1_lat", int'(bus.out_valid), 1);
    chk("t1_cnt", int'(bus.count_out[0 +: CW]), 256);
    chk("t1_short", int'(bus.short_win), 0);
    cyc(0, 2'b00, 1, 0);
    chk("t1_taken", int'(bus.out_valid), 0);

    // 2: alternating 1,0 then all zeros (ch1 random).
    for (int i = 0; i < LEN; i++) cyc(1, {1'($urandom), 1'(i % 2 == 0)}, 1, 0);
    cyc(0, 2'b00, 0, 0);
    chk("t2_alt", int'(bus.count_out[0 +: CW]), 128);
    for (int i = 0; i < LEN; i++) cyc(1, {1'($urandom), 1'b0}, 1, 0);
    cyc(0, 2'b00, 0, 0);
    chk("t2_zero", int'(bus.count_out[0 +: CW]), 0);
    cyc(0, 2'b00, 1, 0);

    // 3: short window of 100 ones.
    for (int i = 0; i < 100; i++) cyc(1, 2'b11, 0, 0);
    cyc(0, 2'b00, 0, 0);
    cyc(0, 2'b00, 0, 0);
    chk("t3_cnt", int'(bus.count_out[0 +: CW]), 100);
    chk("t3_short", int'(bus.short_win), 1);
    cyc(0, 2'b00, 1, 0);

    // 4: two windows with the consumer stalled.
    for (int i = 0; i < 40; i++)  cyc(1, 2'b11, 0, 0);
    cyc(0, 2'b00, 0, 0); cyc(0, 2'b00, 0, 0);
    for (int i = 0; i < 200; i++) cyc(1, 2'b11, 0, 0);
    cyc(0, 2'b00, 0, 0); cyc(0, 2'b00, 0, 0); cyc(0, 2'b00, 0, 0);
    chk("t4_hold", int'(bus.count_out[0 +: CW]), 40);
    chk("t4_ovr", int'(bus.overrun), 1);
    cyc(0, 2'b00, 1, 0);
    chk("t4_drain", int'(bus.out_valid), 0);

    // 5: reset in the middle of a window, then a clean full window.
    for (int i = 0; i < 129; i++) cyc(1, 2'b11, 0, 0);
    cyc(1, 2'b11, 0, 1);
    cyc(0, 2'b00, 0, 0);
    chk("t5_novalid", int'(bus.out_valid), 0);
    for (int i = 0; i < LEN; i++) cyc(1, 2'b11, 0, 0);
    cyc(0, 2'b00, 0, 0);
    chk("t5_cnt", int'(bus.count_out[0 +: CW]), 256);
    chk("t5_ovr", int'(bus.overrun), 0);
    cyc(0, 2'b00, 1, 0);

    // 6: LFSR comparator streams encoding 107 and 89.
    lfsr = 8'b10001101; g0 = 0; g1 = 0;
    for (int i = 0; i < LEN; i++) begin
      bit b0, b1;
      b0 = (lfsr < 8'd107); b1 = (lfsr < 8'd89);
      g0 += int'(b0); g1 += int'(b1);
      cyc(1, {b1, b0}, 0, 0);
      lfsr = lfsr_next(lfsr);
    end
    cyc(0, 2'b00, 0, 0);
    chk("t6_ch0", int'(bus.count_out[0 +: CW]), g0);
    chk("t6_ch1", int'(bus.count_out[CW +: CW]), g1);
    cyc(0, 2'b00, 1, 0);

    // Randomized windows, gaps, stalls and occasional resets.
    for (int w = 0; w < 30; w++) begin
      int hi, lo;
      hi = (($urandom % 4) == 0) ? LEN + 3 : int'($urandom_range(1, 300));
      lo = int'($urandom_range(1, 4));
      for (int i = 0; i < hi; i++)
        cyc(1, CH'($urandom), 1'($urandom), ($urandom % 500) == 0);
      for (int i = 0; i < lo; i++)
        cyc(0, CH'($urandom), 1'($urandom), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
